// File: rtl/booth_mul_ctrl_if.sv
// Request/response bundle for the radix-4 Booth multiplier sequencer.
// master = pipeline side issuing MULT/MULTU, slave = the sequencer.
interface booth_mul_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sign;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_sign, flush, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sign, flush, out_ready,
    output in_ready, out_valid, out_hi, out_lo, busy
  );
endinterface

// File: rtl/booth_mul_ctrl.sv
// Iterative radix-4 Booth multiplier: one partial product per clock, WIDTH/2+1 digits,
// product held in HI/LO until the consumer takes it; flush abandons an in-flight op.
module booth_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  booth_mul_ctrl_if.slave  bus
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [PW-1:0]  mcand_reg, mcand_next;
  logic [PW-1:0]  acc_reg, acc_next;
  logic [PW-1:0]  result_reg, result_next;
  logic [WIDTH+1:0] mult_reg, mult_next;
  logic           prev_reg, prev_next;

  logic [2:0]     group;
  logic [PW-1:0]  pp;
  logic           neg;
  logic [PW-1:0]  acc_sum;

  // Multiplicand is kept pre-shifted by 4^k, so each digit is a plain add mod 2^PW.
  always_comb begin
    group = {mult_reg[1:0], prev_reg};
    pp    = '0;
    neg   = 1'b0;
    case (group)
      3'b001, 3'b010: pp = mcand_reg;
      3'b011:         pp = mcand_reg << 1;
      3'b100: begin
        pp  = ~(mcand_reg << 1);
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp  = ~mcand_reg;
        neg = 1'b1;
      end
      default:        pp = '0;
    endcase
    acc_sum = acc_reg + pp + {{(PW-1){1'b0}}, neg};
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mcand_next  = mcand_reg;
    mult_next   = mult_reg;
    prev_next   = prev_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          state_next = RUN;
          cnt_next   = '0;
          acc_next   = '0;
          prev_next  = 1'b0;
          mcand_next = {{(PW-WIDTH){bus.in_sign & bus.in_a[WIDTH-1]}}, bus.in_a};
          mult_next  = {{2{bus.in_sign & bus.in_b[WIDTH-1]}}, bus.in_b};
        end
      end
      RUN: begin
        acc_next   = acc_sum;
        mcand_next = mcand_reg << 2;
        mult_next  = mult_reg >> 2;
        prev_next  = mult_reg[1];
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next = DONE;
          cnt_next   = '0;
          // A flushed final digit must not leak into HI/LO.
          if (!bus.flush) begin
            result_next = acc_sum;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mult_reg   <= '0;
      prev_reg   <= 1'b0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      mcand_reg  <= mcand_next;
      mult_reg   <= mult_next;
      prev_reg   <= prev_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg == RUN);
  assign bus.out_hi    = result_reg[PW-1:WIDTH];
  assign bus.out_lo    = result_reg[WIDTH-1:0];
endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: vector table, random ops against an
// arithmetic model, and hand-written flush / backpressure / async-reset sequences.
module tb_booth_mul_ctrl;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  booth_mul_ctrl_if #(.WIDTH(W)) bus();
  booth_mul_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] last_exp = '0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Drives one request; returns just after the accept edge with in_valid dropped.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [2*W-1:0] exp);
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sign  = s;
    bus.in_valid = 1'b1;
    check("in_ready_before_accept", bus.in_ready, 1);
    sb_q.push_back(exp);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Called right after an accept edge; checks latency, busy span, hold and result.
  task automatic wait_result(input int delay);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 0;
    logic [2*W-1:0] exp;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) seen = 1;
    end
    check("latency", cyc, 18);
    check("busy_cycles", busy_cnt, 17);
    if (!seen) return;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got out_valid expected empty queue");
      return;
    end
    exp = sb_q.pop_front();
    for (int i = 0; i < delay; i++) begin
      check("hold_product", {bus.out_hi, bus.out_lo}, exp);
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("out_hi", bus.out_hi, exp[2*W-1:W]);
    check("out_lo", bus.out_lo, exp[W-1:0]);
    $display("op: hi=%h lo=%h exp=%h latency=%0d busy=%0d", bus.out_hi, bus.out_lo, exp, cyc, busy_cnt);
    last_exp = exp;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_take", bus.in_ready, 1);
    check("out_valid_after_take", bus.out_valid, 0);
  endtask

  vec_t vecs[4];

  initial begin
    int vcount;
    logic [W-1:0] ra, rb;
    logic rs;

    vecs[0] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, s: 1'b0, hi: 32'hFFFFFFFE, lo: 32'h00000001};
    vecs[1] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, s: 1'b1, hi: 32'h00000000, lo: 32'h00000001};
    vecs[2] = '{a: 32'h80000000, b: 32'h80000000, s: 1'b1, hi: 32'h40000000, lo: 32'h00000000};
    vecs[3] = '{a: 32'hFFFFFFFD, b: 32'h00000007, s: 1'b1, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sign   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_product", {bus.out_hi, bus.out_lo}, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].hi, vecs[i].lo});
      wait_result(0);
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      start_op(ra, rb, rs, model(ra, rb, rs));
      wait_result(int'($urandom_range(0, 2)));
    end

    // Backpressure with a new request waiting behind the held result.
    start_op(32'h12345678, 32'h9ABCDEF0, 1'b0, {32'h0B00EA4E, 32'h242D2080});
    bus.in_a     = 32'h00000009;
    bus.in_b     = 32'h0000000B;
    bus.in_sign  = 1'b0;
    bus.in_valid = 1'b1;
    wait_result(5);
    check("bp_no_early_accept", bus.busy, 0);
    sb_q.push_back(64'd99);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(0);

    // Flush in cycle 9 of RUN.
    start_op(32'hDEADBEEF, 32'h01234567, 1'b1, model(32'hDEADBEEF, 32'h01234567, 1'b1));
    repeat (9) @(negedge clk);
    check("flush_busy_before", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_busy", bus.busy, 0);
    check("flush_product_kept", {bus.out_hi, bus.out_lo}, last_exp);
    vcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    check("flush_no_out_valid", vcount, 0);
    start_op(32'h00000007, 32'hFFFFFFFD, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFEB});
    wait_result(0);

    // Flush coincident with a request in IDLE.
    @(negedge clk);
    bus.in_a     = 32'h00000005;
    bus.in_b     = 32'h00000006;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || !bus.in_ready) vcount++;
    end
    check("idle_flush_no_accept", vcount, 0);

    // Asynchronous reset in cycle 5 of RUN, checked before the next clock edge.
    start_op(32'h11111111, 32'h22222222, 1'b0, model(32'h11111111, 32'h22222222, 1'b0));
    repeat (5) @(negedge clk);
    check("arst_busy_before", bus.busy, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_product", {bus.out_hi, bus.out_lo}, 0);
    void'(sb_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    start_op(32'h00000003, 32'h00000005, 1'b0, 64'd15);
    wait_result(0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
